// File: rtl/aes_ctr_xor_stream.sv
// Ping-pong keystream buffer that XORs a din stream with buffered AES-CTR keystream blocks.
// Each session consumes a fixed number of blocks (XOF or PRF) and ends with a done pulse.
module aes_ctr_xor_stream #(
  parameter int unsigned BLOCK_SIZE        = 128,
  parameter int unsigned BATCH_BLOCKS      = 16,
  parameter int unsigned XOF_TARGET_BLOCKS = 44,
  parameter int unsigned PRF_TARGET_BLOCKS = 8
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_start,
  input  logic                               i_mode,
  input  logic [BLOCK_SIZE*BATCH_BLOCKS-1:0] i_ks_batch,
  input  logic                               i_ks_valid,
  output logic                               o_ks_ready,
  input  logic [BLOCK_SIZE-1:0]              i_din,
  input  logic                               i_din_valid,
  output logic                               o_din_ready,
  output logic [BLOCK_SIZE-1:0]              o_dout,
  output logic                               o_dout_valid,
  input  logic                               i_dout_ready,
  output logic                               o_dout_last,
  output logic                               o_done,
  output logic                               o_ovf
);

  localparam int unsigned BIDX_W = (BATCH_BLOCKS > 1) ? $clog2(BATCH_BLOCKS) : 1;
  localparam int unsigned CNT_W  = 6;

  typedef enum logic [1:0] {StIdle, StActive, StDrain} state_e;

  state_e                                   r_state;
  logic [BATCH_BLOCKS-1:0][BLOCK_SIZE-1:0]  r_slot [2];
  logic                                     r_wp;
  logic                                     r_rp;
  logic [1:0]                               r_cnt;
  logic [BIDX_W-1:0]                        r_bidx;
  logic [CNT_W-1:0]                         r_blk_cnt;
  logic [CNT_W-1:0]                         r_target;
  logic [BLOCK_SIZE-1:0]                    r_dout;
  logic                                     r_dout_valid;
  logic                                     r_dout_last;
  logic                                     r_done;
  logic                                     r_ovf;

  logic                  w_active;
  logic                  w_ks_ready;
  logic                  w_ks_wr;
  logic                  w_ks_drop;
  logic                  w_din_ready;
  logic                  w_din_fire;
  logic                  w_slot_end;
  logic                  w_release;
  logic                  w_final;
  logic                  w_out_hs;
  logic [BLOCK_SIZE-1:0] w_ks_blk;
  logic [1:0]            w_cnt_nxt;

  assign w_active    = (r_state == StActive);
  assign w_ks_ready  = w_active && (r_cnt != 2'd2);
  assign w_ks_wr     = i_ks_valid && w_ks_ready;
  // Batches arriving with no free slot are lost; only flagged while a session is open.
  assign w_ks_drop   = i_ks_valid && !w_ks_ready && (r_state != StIdle);
  assign w_din_ready = w_active && (r_cnt != 2'd0) && (!r_dout_valid || i_dout_ready);
  assign w_din_fire  = i_din_valid && w_din_ready;
  assign w_slot_end  = (r_bidx == BIDX_W'(BATCH_BLOCKS - 1));
  assign w_release   = w_din_fire && w_slot_end;
  assign w_final     = (r_blk_cnt == (r_target - CNT_W'(1)));
  assign w_out_hs    = r_dout_valid && i_dout_ready;
  assign w_ks_blk    = r_slot[r_rp][r_bidx];

  always_comb begin
    w_cnt_nxt = r_cnt;
    unique case ({w_ks_wr, w_release})
      2'b10:   w_cnt_nxt = r_cnt + 2'd1;
      2'b01:   w_cnt_nxt = r_cnt - 2'd1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Keystream storage carries no reset; occupancy tracking decides what is valid.
  always_ff @(posedge i_clk) begin
    if (w_ks_wr) begin
      r_slot[r_wp] <= i_ks_batch;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_wp         <= 1'b0;
      r_rp         <= 1'b0;
      r_cnt        <= 2'd0;
      r_bidx       <= '0;
      r_blk_cnt    <= '0;
      r_target     <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_dout_last  <= 1'b0;
      r_done       <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_ks_drop) begin
        r_ovf <= 1'b1;
      end

      if (w_din_fire) begin
        r_dout       <= i_din ^ w_ks_blk;
        r_dout_valid <= 1'b1;
        r_dout_last  <= w_final;
        r_blk_cnt    <= r_blk_cnt + CNT_W'(1);
      end else if (w_out_hs) begin
        r_dout_valid <= 1'b0;
        r_dout_last  <= 1'b0;
      end

      if (w_ks_wr) begin
        r_wp <= ~r_wp;
      end
      if (w_din_fire) begin
        r_bidx <= w_slot_end ? '0 : r_bidx + BIDX_W'(1);
        if (w_slot_end) begin
          r_rp <= ~r_rp;
        end
      end
      r_cnt <= w_cnt_nxt;

      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state   <= StActive;
            r_target  <= i_mode ? CNT_W'(PRF_TARGET_BLOCKS) : CNT_W'(XOF_TARGET_BLOCKS);
            r_blk_cnt <= '0;
            r_ovf     <= 1'b0;
            r_cnt     <= 2'd0;
            r_wp      <= 1'b0;
            r_rp      <= 1'b0;
            r_bidx    <= '0;
          end
        end
        StActive: begin
          // Final block consumed: leftover keystream is discarded, overriding slot updates.
          if (w_din_fire && w_final) begin
            r_state <= StDrain;
            r_cnt   <= 2'd0;
            r_wp    <= 1'b0;
            r_rp    <= 1'b0;
            r_bidx  <= '0;
          end
        end
        StDrain: begin
          if (w_out_hs && r_dout_last) begin
            r_state <= StIdle;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_ks_ready   = w_ks_ready;
  assign o_din_ready  = w_din_ready;
  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;
  assign o_dout_last  = r_dout_last;
  assign o_done       = r_done;
  assign o_ovf        = r_ovf;

endmodule

// File: tb/tb_aes_ctr_xor_stream.sv
// Scoreboard bench for aes_ctr_xor_stream: PRF/XOF sessions, backpressure, overflow,
// slot-boundary refill and mid-session reset.
module tb_aes_ctr_xor_stream;

  localparam int BS = 128;
  localparam int BB = 16;

  typedef struct packed {
    logic [BS-1:0] data;
    logic          last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             mode;
  logic [BS*BB-1:0] ks_batch;
  logic             ks_valid;
  logic             ks_ready;
  logic [BS-1:0]    din;
  logic             din_valid;
  logic             din_ready;
  logic [BS-1:0]    dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_last;
  logic             done;
  logic             ovf;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_done  = 0;
  int            n_sent  = 0;
  int            target  = 0;
  logic [BS-1:0] q_ks [$];
  exp_t          q_exp [$];

  always #5 clk = ~clk;

  aes_ctr_xor_stream dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_mode       (mode),
    .i_ks_batch   (ks_batch),
    .i_ks_valid   (ks_valid),
    .o_ks_ready   (ks_ready),
    .i_din        (din),
    .i_din_valid  (din_valid),
    .o_din_ready  (din_ready),
    .o_dout       (dout),
    .o_dout_valid (dout_valid),
    .i_dout_ready (dout_ready),
    .o_dout_last  (dout_last),
    .o_done       (done),
    .o_ovf        (ovf)
  );

  task automatic check_eq(input string tag, input logic [BS-1:0] obs, input logic [BS-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BS*BB-1:0] mk_batch(input logic [31:0] tag);
    logic [BS*BB-1:0] b;
    for (int i = 0; i < BB; i++) b[i*BS +: BS] = {tag, 64'h0, 32'(i)};
    return b;
  endfunction

  task automatic push_ks(input logic [BS*BB-1:0] b);
    for (int i = 0; i < BB; i++) q_ks.push_back(b[i*BS +: BS]);
  endtask

  task automatic push_exp(input logic [BS-1:0] d);
    logic [BS-1:0] k;
    k = (q_ks.size() > 0) ? q_ks.pop_front() : '0;
    q_exp.push_back('{data: d ^ k, last: (n_sent == target - 1)});
    n_sent++;
  endtask

  // All stimulus tasks start and end at posedge+1.
  task automatic do_start(input logic m);
    start = 1'b1;
    mode  = m;
    @(posedge clk); #1;
    start  = 1'b0;
    n_sent = 0;
    target = m ? 8 : 44;
    q_ks.delete();
  endtask

  task automatic send_batch(input logic [31:0] tag, input logic acc);
    ks_batch = mk_batch(tag);
    ks_valid = 1'b1;
    @(negedge clk);
    check_eq("ks_ready", ks_ready, acc);
    @(posedge clk); #1;
    ks_valid = 1'b0;
    if (acc) push_ks(ks_batch);
  endtask

  task automatic send_din(input logic [BS-1:0] d);
    bit ok = 0;
    din       = d;
    din_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (din_ready) ok = 1;
    end
    if (ok) push_exp(d);
    else check_eq("din_handshake", din_ready, 1);
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic run_dins(input int n);
    for (int i = 0; i < n; i++) send_din({$urandom, $urandom, $urandom, $urandom});
  endtask

  // Final block of a slot consumed on the same edge that a new batch is written.
  task automatic send_din_batch(input logic [BS-1:0] d, input logic [31:0] tag);
    ks_batch  = mk_batch(tag);
    ks_valid  = 1'b1;
    din       = d;
    din_valid = 1'b1;
    @(negedge clk);
    check_eq("bnd_din_ready", din_ready, 1);
    check_eq("bnd_ks_ready", ks_ready, 1);
    push_exp(d);
    push_ks(ks_batch);
    @(posedge clk); #1;
    ks_valid  = 1'b0;
    din_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n0 = n_done;
    for (int t = 0; t < 300 && n_done == n0; t++) @(negedge clk);
    check_eq("done_seen", n_done - n0, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clk);
    check_eq({tag, "_ks_ready"}, ks_ready, 0);
    check_eq({tag, "_din_ready"}, din_ready, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check_eq({tag, "_ks_ready"}, ks_ready, 0);
    check_eq({tag, "_din_ready"}, din_ready, 0);
    check_eq({tag, "_dout_valid"}, dout_valid, 0);
    check_eq({tag, "_dout_last"}, dout_last, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_ovf"}, ovf, 0);
    check_eq({tag, "_dout"}, dout, 0);
  endtask

  // Output monitor: scoreboard pops, done timing, and stall stability.
  initial begin
    exp_t          e;
    logic          exp_done = 1'b0;
    logic          stall_prev = 1'b0;
    logic [BS-1:0] stall_val = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q_exp.delete();
        exp_done   = 1'b0;
        stall_prev = 1'b0;
      end else begin
        check_eq("done_pulse", done, exp_done);
        if (done) n_done++;
        exp_done = dout_valid && dout_ready && dout_last;
        if (dout_valid && dout_ready) begin
          if (q_exp.size() == 0) begin
            check_eq("unexpected_dout", dout_valid, 0);
          end else begin
            e = q_exp.pop_front();
            check_eq("dout", dout, e.data);
            check_eq("dout_last", dout_last, e.last);
          end
        end
        if (dout_valid && !dout_ready) begin
          if (stall_prev) check_eq("stall_hold", dout, stall_val);
          check_eq("stall_din_ready", din_ready, 0);
          stall_prev = 1'b1;
          stall_val  = dout;
        end else begin
          stall_prev = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int saved_done;
    rst        = 1'b1;
    start      = 1'b0;
    mode       = 1'b0;
    ks_batch   = '0;
    ks_valid   = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // Batch in IDLE is dropped without raising ovf.
    send_batch(32'hDEAD, 1'b0);
    @(negedge clk);
    check_eq("idle_no_ovf", ovf, 0);
    @(posedge clk); #1;

    // PRF: block i = i, din = 0, plus an ignored start mid-session.
    do_start(1'b1);
    send_batch(32'h0, 1'b1);
    start = 1'b1;
    mode  = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) send_din('0);
    wait_done();
    check_idle_outputs("prf_idle");

    // XOF with slot-boundary refill and a 5-cycle stall.
    do_start(1'b0);
    send_batch(32'h1, 1'b1);
    run_dins(15);
    send_din_batch({$urandom, $urandom, $urandom, $urandom}, 32'h2);
    @(negedge clk);
    check_eq("bnd_cnt_kept_ks", ks_ready, 1);
    check_eq("bnd_cnt_kept_din", din_ready, 1);
    @(posedge clk); #1;
    run_dins(5);
    send_din({$urandom, $urandom, $urandom, $urandom});
    dout_ready = 1'b0;
    fork
      begin
        repeat (5) @(posedge clk);
        #1;
        dout_ready = 1'b1;
      end
      send_din({$urandom, $urandom, $urandom, $urandom});
    join
    run_dins(9);
    send_batch(32'h3, 1'b1);
    run_dins(12);
    wait_done();
    check_idle_outputs("xof_idle");
    @(negedge clk);
    check_eq("xof_no_ovf", ovf, 0);
    @(posedge clk); #1;

    // Overflow: third batch with both slots full.
    do_start(1'b0);
    send_batch(32'h4, 1'b1);
    send_batch(32'h5, 1'b1);
    send_batch(32'h6, 1'b0);
    @(negedge clk);
    check_eq("ovf_set", ovf, 1);
    @(posedge clk); #1;
    run_dins(16);
    send_batch(32'h7, 1'b1);
    run_dins(16);
    @(negedge clk);
    check_eq("ovf_sticky", ovf, 1);
    @(posedge clk); #1;
    run_dins(12);
    wait_done();
    @(negedge clk);
    check_eq("ovf_idle", ovf, 1);
    @(posedge clk); #1;
    do_start(1'b1);
    @(negedge clk);
    check_eq("ovf_clear", ovf, 0);
    @(posedge clk); #1;
    send_batch(32'h8, 1'b1);
    run_dins(8);
    wait_done();

    // Reset at blk_cnt=20 of an XOF session, then a clean PRF session.
    do_start(1'b0);
    send_batch(32'h9, 1'b1);
    send_batch(32'hA, 1'b1);
    run_dins(20);
    saved_done = n_done;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    q_ks.delete();
    repeat (5) @(posedge clk);
    #1;
    check_eq("no_done_after_rst", n_done, saved_done);
    do_start(1'b1);
    send_batch(32'hB, 1'b1);
    run_dins(8);
    wait_done();

    repeat (5) @(negedge clk);
    check_eq("sb_empty", q_exp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_ctr_xor_stream.md
AES_CTR_XOR_STREAM -- requirements
Module: aes_ctr_xor_stream

Interface
REQ-001 SHALL have one clock domain; reset is synchronous and active-high.
REQ-002 Parameters (name, default, meaning):
- BLOCK_SIZE, 128, bits per block.
- BATCH_BLOCKS, 16, blocks per keystream batch.
- XOF_TARGET_BLOCKS, 44, blocks per session in mode 0.
- PRF_TARGET_BLOCKS, 8, blocks per session in mode 1.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, session start pulse.
- mode, in, 1, 0=XOF, 1=PRF; latched on accepted start.
- ks_batch, in, BLOCK_SIZE*BATCH_BLOCKS, keystream batch; block i at bits [(i+1)*128-1 -: 128].
- ks_valid, in, 1, one-cycle batch strobe (the generator's finished pulse).
- ks_ready, out, 1, a free batch slot exists and session active.
- din, in, BLOCK_SIZE, plaintext/ciphertext block.
- din_valid, in, 1; din_ready, out, 1.
- dout, out, BLOCK_SIZE, din XOR keystream block.
- dout_valid, out, 1; dout_ready, in, 1.
- dout_last, out, 1, dout is final block of session.
- done, out, 1, one-cycle session-complete pulse.
- ovf, out, 1, sticky: batch strobed while ks_ready low.

Function
REQ-004 SHALL implement FSM IDLE, ACTIVE, DRAIN; reset state IDLE.
REQ-005 IDLE -> ACTIVE on start=1; latch mode; target = mode ? PRF_TARGET_BLOCKS : XOF_TARGET_BLOCKS; clear blk_cnt and ovf.
REQ-006 start while not IDLE SHALL be ignored.
REQ-007 SHALL buffer two batch slots (ping-pong): write pointer wp, read pointer rp, occupancy cnt 0..2, in-slot read index bidx 0..15.
REQ-008 ks_ready = ACTIVE and cnt<2; ks_valid and ks_ready writes ks_batch to slot wp, toggles wp, cnt+1.
REQ-009 ks_valid while ks_ready=0 SHALL drop the batch and set ovf (in ACTIVE/DRAIN only); in IDLE, ks_valid SHALL be dropped silently.
REQ-010 din_ready = ACTIVE and cnt>0 and (dout_valid=0 or dout_ready=1).
REQ-011 din handshake SHALL register dout = din XOR slot[rp] block bidx, dout_valid=1, dout_last = (blk_cnt==target-1), and increment blk_cnt; latency 1 cycle.
REQ-012 dout_valid SHALL hold with dout stable until dout_ready; dout_valid clears on dout_ready with no new din handshake.
REQ-013 On consume of bidx=15: bidx->0, toggle rp, cnt-1; otherwise bidx+1.
REQ-014 Simultaneous slot write and slot release SHALL leave cnt unchanged.
REQ-015 On consuming block target-1: ACTIVE -> DRAIN; all buffered slots flushed (cnt=0, wp=rp=0, bidx=0); unused keystream blocks (e.g. 4 of 48 in XOF) discarded.
REQ-016 DRAIN: din_ready=0, ks_ready=0; on dout_valid and dout_ready and dout_last -> IDLE with done=1 for exactly one cycle.
REQ-017 blk_cnt SHALL be 6 bits; XOF consumes 3 batches, PRF consumes 1 batch (8 of 16 blocks).

Reset
REQ-018 rst=1 SHALL force state IDLE, cnt=wp=rp=bidx=blk_cnt=0, and outputs ks_ready, din_ready, dout_valid, dout_last, done, ovf to 0, and dout to 0.
REQ-019 rst mid-session SHALL abandon the session; no done pulse; buffered keystream lost.

Verification
REQ-020 PRF session: start mode=1, one batch with block i=0x..i, din=0 ×8 -> dout=block 0..7 in order, dout_last on 8th, done one cycle after its handshake.
REQ-021 XOF session: start mode=0, 3 batches, 44 din blocks -> 44 outputs, blocks 44..47 discarded, done once, state IDLE.
REQ-022 Backpressure: dout_ready=0 for 5 cycles mid-stream -> dout stable, din_ready=0, no block lost or duplicated.
REQ-023 Overflow: two batches buffered, third ks_valid -> ks_ready=0, ovf=1 sticky until next start; data stream uses first two batches unaffected.
REQ-024 Slot boundary: consume block 15 in same cycle as new batch write -> cnt unchanged, next output uses block 0 of next slot.
REQ-025 Reset at blk_cnt=20 of XOF -> all outputs 0, no done; subsequent PRF session completes normally.
